// File: rtl/fetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_buffer
//
// Instruction fetch stage with a prefetch queue. It sits between the
// instruction memory port and decode. It generates sequential fetch PCs,
// requests words ahead of decode, and buffers up to DEPTH {PC, instruction}
// pairs. A redirect (branch, jump or trap) flushes the queue and restarts
// fetch at the new address.
//
// Ports
//   i_CLK, i_RST        clock; synchronous active-high reset
//   i_EN                fetch enable (0 stops new requests, the queue still drains)
//   o_IMEM_REQ          memory request, combinational
//   o_IMEM_ADDR         request address (current fetch PC)
//   i_IMEM_GNT          grant; i_IMEM_DATA is valid in the same cycle
//   i_IMEM_DATA         instruction word from memory
//   o_INSTR             head instruction, or NOOP when the queue is empty
//   o_INSTR_PC          PC of the head instruction, or 0 when the queue is empty
//   o_INSTR_VALID       queue not empty
//   i_INSTR_READY       decode consumes the head when VALID & READY
//   i_REDIRECT          flush the queue and restart fetch at i_REDIRECT_PC
//   i_REDIRECT_PC       new fetch address; bits [1:0] are ignored
//   o_COUNT             number of occupied entries
// -----------------------------------------------------------------------------
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOOP     = 32'h0000_0013
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    input  logic                       i_EN,
    output logic                       o_IMEM_REQ,
    output logic [31:0]                o_IMEM_ADDR,
    input  logic                       i_IMEM_GNT,
    input  logic [31:0]                i_IMEM_DATA,
    output logic [31:0]                o_INSTR,
    output logic [31:0]                o_INSTR_PC,
    output logic                       o_INSTR_VALID,
    input  logic                       i_INSTR_READY,
    input  logic                       i_REDIRECT,
    input  logic [31:0]                i_REDIRECT_PC,
    output logic [$clog2(DEPTH):0]     o_COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Control state (reset)
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;

    // Queue storage (data only, never reset)
    logic [31:0] entry_pc_q    [DEPTH];
    logic [31:0] entry_instr_q [DEPTH];

    logic full;
    logic req;
    logic valid;
    logic push;
    logic pop;

    // The low two bits of the redirect target are dropped on purpose.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^i_REDIRECT_PC[1:0];

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        // A full queue blocks the request even when a pop happens this cycle,
        // which keeps REQ independent of READY.
        req   = ~i_RST & i_EN & ~i_REDIRECT & ~full;
        valid = ~i_RST & (count_q != '0);
        push  = req & i_IMEM_GNT;
        // Redirect discards the head, so a handshake in that cycle is void.
        pop   = valid & i_INSTR_READY & ~i_REDIRECT;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (i_REDIRECT) begin
            fetch_pc_d = {i_REDIRECT_PC[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // push is already suppressed in reset and redirect cycles.
    always_ff @(posedge i_CLK) begin
        if (push) begin
            entry_pc_q[wr_ptr_q]    <= fetch_pc_q;
            entry_instr_q[wr_ptr_q] <= i_IMEM_DATA;
        end
    end

    assign o_IMEM_REQ    = req;
    assign o_IMEM_ADDR   = fetch_pc_q;
    assign o_INSTR_VALID = valid;
    assign o_INSTR       = valid ? entry_instr_q[rd_ptr_q] : NOOP;
    assign o_INSTR_PC    = valid ? entry_pc_q[rd_ptr_q]    : 32'h0000_0000;
    assign o_COUNT       = i_RST ? '0 : count_q;

endmodule
